// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR with run/step/hold control, lock-up repair,
// period measurement and registered 7-segment hex digits.
module lfsr_hex_display #(
  parameter int unsigned            WIDTH    = 8,
  parameter logic [WIDTH-1:0]       TAPS     = 8'h1D,
  parameter logic [WIDTH-1:0]       SEED     = 8'h01,
  parameter int unsigned            PRESCALE = 1,
  parameter int unsigned            CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [1:0]             mode,
  input  logic                   step,
  output logic [WIDTH-1:0]       state,
  output logic [8*WIDTH/4-1:0]   seg_out,
  output logic                   lockup,
  output logic                   period_valid,
  output logic [CNT_W-1:0]       period_len
);

  typedef enum logic [1:0] {
    M_HOLD = 2'd0,
    M_RUN  = 2'd1,
    M_STEP = 2'd2,
    M_RSVD = 2'd3
  } mode_e;

  localparam int unsigned SW = 8 * WIDTH / 4;
  localparam int unsigned PW = 17;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pv_q, pv_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic             lock_q, lock_d;
  logic [SW-1:0]    seg_q, seg_d;
  logic [PW-1:0]    pre_q, pre_d, pre_eff;
  logic [1:0]       mode_q;
  logic             adv;
  logic             fb;
  logic [WIDTH-1:0] nxt;

  // Active-low glyphs: bit7 = a ... bit1 = g, bit0 = dp (off).
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    unique case (n)
      4'h0: g = 8'h03;
      4'h1: g = 8'h9F;
      4'h2: g = 8'h25;
      4'h3: g = 8'h0D;
      4'h4: g = 8'h99;
      4'h5: g = 8'h49;
      4'h6: g = 8'h41;
      4'h7: g = 8'h1F;
      4'h8: g = 8'h01;
      4'h9: g = 8'h09;
      4'hA: g = 8'h11;
      4'hB: g = 8'hC1;
      4'hC: g = 8'h63;
      4'hD: g = 8'h85;
      4'hE: g = 8'h61;
      4'hF: g = 8'h71;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  // Advance strobe and prescaler; a mode change restarts the count.
  always_comb begin
    pre_eff = (mode != mode_q) ? '0 : pre_q;
    pre_d   = '0;
    adv     = 1'b0;
    unique case (mode_e'(mode))
      M_RUN: begin
        adv   = (pre_eff == PRE_MAX);
        pre_d = adv ? '0 : pre_eff + 1'b1;
      end
      M_STEP:  adv = step;
      default: adv = 1'b0;
    endcase
  end

  // Next LFSR value and saturating period counter increment.
  always_comb begin
    fb      = ^(state_q & TAPS);
    nxt     = {fb, state_q[WIDTH-1:1]};
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  // Load beats lock-up repair beats advance.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    pv_d    = pv_q;
    plen_d  = plen_q;
    lock_d  = 1'b0;
    if (load) begin
      if (load_data != '0) begin
        state_d = load_data;
        ref_d   = load_data;
      end else begin
        state_d = SEED;
        ref_d   = SEED;
        lock_d  = 1'b1;
      end
      cnt_d  = '0;
      pv_d   = 1'b0;
      plen_d = '0;
    end else if (state_q == '0) begin
      state_d = SEED;
      lock_d  = 1'b1;
    end else if (adv) begin
      state_d = nxt;
      cnt_d   = cnt_inc;
      if (nxt == ref_q && !pv_q) begin
        plen_d = cnt_inc;
        pv_d   = 1'b1;
      end
    end
  end

  // Display digits follow the state register by one cycle.
  always_comb begin
    seg_d = '1;
    for (int k = 0; k < WIDTH / 4; k++) begin
      seg_d[8*k +: 8] = hex_glyph(state_q[4*k +: 4]);
    end
  end

  // State, measurement and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
      ref_q   <= SEED;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      plen_q  <= '0;
      lock_q  <= 1'b0;
      seg_q   <= '1;
      pre_q   <= '0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      plen_q  <= plen_d;
      lock_q  <= lock_d;
      seg_q   <= seg_d;
      pre_q   <= pre_d;
      mode_q  <= mode;
    end
  end

  assign state        = state_q;
  assign seg_out      = seg_q;
  assign lockup       = lock_q;
  assign period_valid = pv_q;
  assign period_len   = plen_q;

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Self-checking bench for lfsr_hex_display: default, 4-bit
// and prescaled instances against a behavioural model.
module tb_lfsr_hex_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] glyph [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // default instance
  logic        ld8 = 0, st8 = 0;
  logic [7:0]  ldd8 = 0;
  logic [1:0]  md8 = 0;
  logic [7:0]  s8;
  logic [15:0] seg8;
  logic        lk8, pv8;
  logic [7:0]  pl8;

  // 4-bit instance
  logic        ld4 = 0, st4 = 0;
  logic [3:0]  ldd4 = 0;
  logic [1:0]  md4 = 0;
  logic [3:0]  s4;
  logic [7:0]  seg4;
  logic        lk4, pv4;
  logic [7:0]  pl4;

  // prescaled instance
  logic        ldp = 0, stp = 0;
  logic [7:0]  lddp = 0;
  logic [1:0]  mdp = 0;
  logic [7:0]  sp;
  logic [15:0] segp;
  logic        lkp, pvp;
  logic [7:0]  plp;

  lfsr_hex_display u8 (
    .clk(clk), .rst(rst), .load(ld8), .load_data(ldd8),
    .mode(md8), .step(st8), .state(s8), .seg_out(seg8),
    .lockup(lk8), .period_valid(pv8), .period_len(pl8)
  );

  lfsr_hex_display #(
    .WIDTH(4), .TAPS(4'b0011), .SEED(4'h1),
    .PRESCALE(1), .CNT_W(8)
  ) u4 (
    .clk(clk), .rst(rst), .load(ld4), .load_data(ldd4),
    .mode(md4), .step(st4), .state(s4), .seg_out(seg4),
    .lockup(lk4), .period_valid(pv4), .period_len(pl4)
  );

  lfsr_hex_display #(.PRESCALE(4)) up (
    .clk(clk), .rst(rst), .load(ldp), .load_data(lddp),
    .mode(mdp), .step(stp), .state(sp), .seg_out(segp),
    .lockup(lkp), .period_valid(pvp), .period_len(plp)
  );

  // Parity of tapped bits shifted in at the top after a right shift.
  function automatic int unsigned lfsr_next(
    input int unsigned s, input int unsigned taps, input int w);
    int unsigned ones;
    ones = $countones(s & taps);
    return ((s >> 1) | ((ones % 2) << (w - 1))) & ((1 << w) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s8 !== 8'h01) begin
      errors++; $display("FAIL reset_state got %h want 01", s8);
    end
    checks++;
    if (seg8 !== 16'hFFFF) begin
      errors++; $display("FAIL reset_seg got %h want ffff", seg8);
    end
    checks++;
    if (pv8 !== 1'b0 || pl8 !== 8'h00 || lk8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got pv=%b len=%h lk=%b want 0",
               pv8, pl8, lk8);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (seg8 !== 16'h039F) begin
      errors++; $display("FAIL reset_glyph got %h want 039f", seg8);
    end
  endtask

  task automatic test_step();
    md8 = 2'd2; st8 = 1'b1;
    tick();
    checks++;
    if (s8 !== 8'h80) begin
      errors++; $display("FAIL step1 got %h want 80", s8);
    end
    tick();
    checks++;
    if (s8 !== 8'h40) begin
      errors++; $display("FAIL step2 got %h want 40", s8);
    end
    st8 = 1'b0;
    tick();
    checks++;
    if (s8 !== 8'h40) begin
      errors++; $display("FAIL step_low got %h want 40", s8);
    end
    md8 = 2'd0; st8 = 1'b1;
    tick();
    checks++;
    if (s8 !== 8'h40) begin
      errors++; $display("FAIL step_ignored got %h want 40", s8);
    end
    md8 = 2'd2; ld8 = 1'b1; ldd8 = 8'h1D;
    tick();
    checks++;
    if (s8 !== 8'h1D) begin
      errors++; $display("FAIL load_over_step got %h want 1d", s8);
    end
    ld8 = 1'b0;
    tick();
    checks++;
    if (s8 !== 8'h0E) begin
      errors++; $display("FAIL step_after_load got %h want 0e", s8);
    end
    st8 = 1'b0; md8 = 2'd0;
    tick();
  endtask

  task automatic test_run_w4();
    int unsigned exp;
    exp = 1;
    md4 = 2'd1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp = lfsr_next(exp, 4'b0011, 4);
      checks++;
      if (s4 !== 4'(exp)) begin
        errors++;
        $display("FAIL w4_seq[%0d] got %h want %h", i, s4, exp);
      end
      if (i == 14) begin
        checks++;
        if (pv4 !== 1'b0) begin
          errors++; $display("FAIL w4_early_valid got %b want 0", pv4);
        end
      end
    end
    checks++;
    if (pv4 !== 1'b1 || pl4 !== 8'd15) begin
      errors++;
      $display("FAIL w4_period got pv=%b len=%0d want 1/15", pv4, pl4);
    end
    md4 = 2'd0;
    tick();
  endtask

  task automatic test_prescale();
    int unsigned exp;
    exp = 8'h01;
    mdp = 2'd1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i % 4 == 0) exp = lfsr_next(exp, 8'h1D, 8);
      checks++;
      if (sp !== 8'(exp)) begin
        errors++;
        $display("FAIL pre_run[%0d] got %h want %h", i, sp, exp);
      end
    end
    mdp = 2'd0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (sp !== 8'(exp)) begin
        errors++;
        $display("FAIL pre_hold[%0d] got %h want %h", i, sp, exp);
      end
    end
    mdp = 2'd1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 4 == 0) exp = lfsr_next(exp, 8'h1D, 8);
      checks++;
      if (sp !== 8'(exp)) begin
        errors++;
        $display("FAIL pre_rerun[%0d] got %h want %h", i, sp, exp);
      end
    end
    mdp = 2'd0;
  endtask

  task automatic test_load_zero();
    md8 = 2'd1; ld8 = 1'b1; ldd8 = 8'h01;
    tick();
    ld8 = 1'b0;
    repeat (254) tick();
    checks++;
    if (pv8 !== 1'b0) begin
      errors++; $display("FAIL period_early got %b want 0", pv8);
    end
    tick();
    checks++;
    if (pv8 !== 1'b1 || pl8 !== 8'd255 || s8 !== 8'h01) begin
      errors++;
      $display("FAIL period_255 got pv=%b len=%0d s=%h want 1/255/01",
               pv8, pl8, s8);
    end
    ld8 = 1'b1; ldd8 = 8'h00;
    tick();
    checks++;
    if (s8 !== 8'h01 || lk8 !== 1'b1) begin
      errors++;
      $display("FAIL load_zero got s=%h lk=%b want 01/1", s8, lk8);
    end
    checks++;
    if (pv8 !== 1'b0 || pl8 !== 8'h00) begin
      errors++;
      $display("FAIL load_clear got pv=%b len=%h want 0/0", pv8, pl8);
    end
    ld8 = 1'b0; md8 = 2'd0;
    tick();
    checks++;
    if (lk8 !== 1'b0 || s8 !== 8'h01) begin
      errors++;
      $display("FAIL lockup_pulse got lk=%b s=%h want 0/01", lk8, s8);
    end
  endtask

  task automatic test_random();
    int unsigned mst, mref, mcnt, mlen, prev, nxt;
    bit          mpv, mlock, adv;
    logic [7:0]  d;
    mst = s8; mref = 0; mcnt = 0; mpv = 0; mlen = 0;
    for (int i = 0; i < 400; i++) begin
      ld8  = (i == 0) || ($urandom_range(0, 19) == 0);
      d    = ($urandom_range(0, 3) == 0) ? 8'h00
           : 8'($urandom_range(1, 255));
      ldd8 = d;
      md8  = 2'($urandom_range(0, 3));
      st8  = 1'($urandom_range(0, 1));
      adv  = (md8 == 2'd1) || (md8 == 2'd2 && st8);
      prev = mst;
      mlock = 0;
      if (ld8) begin
        mst   = (d == 0) ? 1 : d;
        mref  = mst;
        mlock = (d == 0);
        mcnt = 0; mpv = 0; mlen = 0;
      end else if (adv) begin
        nxt  = lfsr_next(mst, 8'h1D, 8);
        mcnt = (mcnt < 255) ? mcnt + 1 : 255;
        if (nxt == mref && !mpv) begin
          mpv = 1; mlen = mcnt;
        end
        mst = nxt;
      end
      tick();
      checks++;
      if (s8 !== 8'(mst) || lk8 !== mlock) begin
        errors++;
        $display("FAIL rnd_state[%0d] got %h/%b want %h/%b",
                 i, s8, lk8, mst, mlock);
      end
      checks++;
      if (pv8 !== mpv || pl8 !== 8'(mlen)) begin
        errors++;
        $display("FAIL rnd_period[%0d] got %b/%0d want %b/%0d",
                 i, pv8, pl8, mpv, mlen);
      end
      checks++;
      if (seg8 !== {glyph[prev[7:4]], glyph[prev[3:0]]}) begin
        errors++;
        $display("FAIL rnd_seg[%0d] got %h want %h%h", i, seg8,
                 glyph[prev[7:4]], glyph[prev[3:0]]);
      end
    end
    ld8 = 1'b0; md8 = 2'd0; st8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    md8 = 2'd1; ld8 = 1'b1; ldd8 = 8'hAF;
    tick();
    ld8 = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (s8 !== 8'h01 || seg8 !== 16'hFFFF) begin
      errors++;
      $display("FAIL mid_reset got s=%h seg=%h want 01/ffff", s8, seg8);
    end
    checks++;
    if (pv8 !== 1'b0 || pl8 !== 8'h00 || lk8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags got pv=%b len=%h lk=%b want 0",
               pv8, pl8, lk8);
    end
    @(negedge clk);
    rst = 1'b0; md8 = 2'd0;
    #1;
    checks++;
    if (seg8 !== 16'hFFFF) begin
      errors++; $display("FAIL mid_blank got %h want ffff", seg8);
    end
    tick();
    checks++;
    if (seg8 !== 16'h039F) begin
      errors++; $display("FAIL mid_glyph got %h want 039f", seg8);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_w4();
    test_prescale();
    test_load_zero();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_hex_display.md
Name: lfsr_hex_display

Overview:
- Parametrised Fibonacci LFSR with programmable taps and seed, run/step/hold modes, and a free-run prescaler.
- Drives one registered 7-segment hex digit per 4 state bits.
- Detects the all-zero lock-up state and repairs it.
- Measures the sequence period from the last load point.
- Successor to the fixed 8-bit LFSR plus two-digit display; sits between board switches/buttons and the segment pins.

Parameters:
- WIDTH, 8, LFSR width; multiple of 4, range 4..32.
- TAPS, 8'h1D, feedback mask, WIDTH bits; bit i set means state[i] feeds the XOR.
- SEED, 8'h01, reset and lock-up repair value, WIDTH bits; must be non-zero.
- PRESCALE, 1, free-run advance interval in cycles; range 1..2^16.
- CNT_W, 8, width of the period counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  when 1, capture load_data this cycle.
- load_data  in  WIDTH  value to load.
- mode  in  2  0 = HOLD, 1 = RUN, 2 = STEP, 3 = reserved (acts as HOLD).
- step  in  1  in STEP mode, each cycle it is high gives one advance.
- state  out  WIDTH  current LFSR register.
- seg_out  out  8*WIDTH/4  digit k in bits [8k+7:8k] shows nibble state[4k+3:4k]; active-low; bit7 = a ... bit1 = g; bit0 = dp, always 1.
- lockup  out  1  one-cycle pulse when zero was repaired to SEED.
- period_valid  out  1  sticky; period has been measured.
- period_len  out  CNT_W  measured period.

Behaviour:
- Reset values:
  - state = SEED; seg_out = all 1s (blank); lockup = 0; period_valid = 0; period_len = 0.
  - ref = SEED; cnt = 0; prescaler = 0.
- Advance function: fb = XOR-reduce(state & TAPS); next = {fb, state[WIDTH-1:1]} (right shift, feedback into MSB).
- adv per cycle:
  - RUN: adv = 1 when prescaler == PRESCALE-1, then prescaler wraps to 0; otherwise prescaler increments.
  - STEP: adv = step.
  - HOLD and reserved: adv = 0.
  - Any change of mode clears the prescaler.
- Priority each cycle: load > adv > hold.
- Load:
  - load_data != 0: state = ref = load_data.
  - load_data == 0: state = ref = SEED, and lockup pulses the next cycle.
  - Every load also clears cnt, period_valid and period_len.
- Lock-up repair: if state is 0 at a cycle edge without a load (reachable only through a single-event upset), state = SEED and lockup pulses; this takes priority over adv.
- Period measurement:
  - On each adv, cnt = cnt + 1, saturating at all 1s.
  - If next == ref and period_valid == 0: period_len = cnt + 1 (saturated) and period_valid = 1.
  - Both stay stable until the next load or reset; cnt continues counting.
- Display:
  - seg_out is registered from state with exactly 1 cycle of latency; the first post-reset cycle shows the SEED glyphs.
  - Standard hex font, lowercase b and d; 6 lit with segment a, 7 without segment f, 9 with segment d.
  - Glyphs: 0 = 8'h03, 1 = 8'h9F, 8 = 8'h01, A = 8'h11, F = 8'h71.
- Simultaneous events:
  - load and adv in the same cycle: only the load takes effect; the prescaler still runs.
  - step outside STEP mode is ignored.
- Reset mid-operation: all registers return immediately (asynchronously) to reset values; period data is lost.

Test Plan:
- Reset, default instance → state = 8'h01; after 1 cycle seg_out = {8'h03, 8'h9F}; period_valid = 0.
- STEP mode, step high 2 cycles from 8'h01 → 8'h80, then 8'h40. Separately, load 8'h1D then one step → 8'h0E.
- Instance WIDTH=4, TAPS=4'b0011, SEED=4'h1, CNT_W=8, mode RUN, PRESCALE=1 → 15 cycles visit 1, 8, 4, 2, 9, C, 6, B, 5, A, D, E, F, 7, 3, 1; period_valid rises with period_len = 15.
- RUN mode, PRESCALE=4 → state changes exactly every 4th cycle. Switching to HOLD mid-count → state frozen. Back to RUN → first advance 4 cycles later.
- Load 0 while in RUN with adv asserted the same cycle → state = SEED (no advance), lockup = 1 for exactly 1 cycle, cnt/period cleared.
- Load 8'hAF, then assert rst mid-sequence → all outputs return to reset values immediately; seg_out blank, then 8'h03 / 8'h9F one cycle after release.
